// File: rtl/sonar_pkg.sv
// Shared types and constants for the ultrasonic ranging / filtering path.
package sonar_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StCapture,
        StUpdate
    } sonar_state_t;

    localparam int CM_W  = 16;
    localparam int SUM_W = 18;

    localparam int unsigned DEF_MAX_CM  = 400;
    localparam int unsigned DEF_NEAR_CM = 20;
    localparam int unsigned DEF_FAR_CM  = 30;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/distance_filter.sv
// Captures one clamped cm sample per valid echo pulse, averages the last four,
// and drives a hysteretic proximity flag plus a sticky no-echo timeout flag.
module distance_filter
    import sonar_pkg::*;
#(
    parameter int unsigned MAX_CM          = DEF_MAX_CM,
    parameter int unsigned NEAR_CM         = DEF_NEAR_CM,
    parameter int unsigned FAR_CM          = DEF_FAR_CM,
    parameter int unsigned MIN_ECHO_CYCLES = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 6000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            echo,
    input  logic            enable,
    input  logic [CM_W-1:0] cm_in,
    output logic [CM_W-1:0] avg_cm,
    output logic            sample_valid,
    output logic            near,
    output logic            timeout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LEN_W = $clog2(MIN_ECHO_CYCLES + 1);

    localparam logic [CM_W-1:0]  MAX_V  = CM_W'(MAX_CM);
    localparam logic [CM_W-1:0]  NEAR_V = CM_W'(NEAR_CM);
    localparam logic [CM_W-1:0]  FAR_V  = CM_W'(FAR_CM);
    localparam logic [TMO_W-1:0] TMO_V  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [LEN_W-1:0] LEN_V  = LEN_W'(MIN_ECHO_CYCLES);

    sonar_state_t     state;
    logic             echo_s;
    logic             echo_d;
    logic             rise;
    logic             fall;
    logic [LEN_W-1:0] len_q;
    logic [CM_W-1:0]  hist [4];
    logic             filled;
    logic [TMO_W-1:0] tmo_cnt;

    logic [CM_W-1:0]  sample;
    logic [CM_W-1:0]  hist_n [4];
    logic [SUM_W-1:0] sum;
    logic [CM_W-1:0]  avg_n;
    logic             near_n;

    sync2 u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .d     (echo),
        .q     (echo_s)
    );

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    // First sample after reset preloads every history slot.
    always_comb begin
        sample    = (cm_in > MAX_V) ? MAX_V : cm_in;
        hist_n[0] = sample;
        hist_n[1] = filled ? hist[0] : sample;
        hist_n[2] = filled ? hist[1] : sample;
        hist_n[3] = filled ? hist[2] : sample;
        sum       = SUM_W'(hist_n[0]) + SUM_W'(hist_n[1])
                  + SUM_W'(hist_n[2]) + SUM_W'(hist_n[3]);
        avg_n     = CM_W'(sum >> 2);
        near_n    = near;
        if (avg_n < NEAR_V) begin
            near_n = 1'b1;
        end else if (avg_n >= FAR_V) begin
            near_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            echo_d       <= 1'b0;
            len_q        <= '0;
            filled       <= 1'b0;
            tmo_cnt      <= '0;
            avg_cm       <= '0;
            sample_valid <= 1'b0;
            near         <= 1'b0;
            timeout      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
        end else begin
            echo_d       <= echo_s;
            sample_valid <= 1'b0;

            if (enable) begin
                if (tmo_cnt != TMO_V) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_cnt == TMO_V) begin
                timeout <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (enable && rise) begin
                        state <= StMeasure;
                        // The rising-edge cycle is the first high cycle.
                        len_q <= LEN_W'(1);
                    end
                end
                StMeasure: begin
                    if (!enable) begin
                        state <= StIdle;
                    end else if (echo_s) begin
                        if (len_q != LEN_V) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                    end else if (fall) begin
                        state <= (len_q < LEN_V) ? StIdle : StCapture;
                    end
                end
                StCapture: begin
                    // Results are registered here so they are visible during UPDATE,
                    // two cycles after the synchronized falling edge.
                    for (int i = 0; i < 4; i++) begin
                        hist[i] <= hist_n[i];
                    end
                    filled       <= 1'b1;
                    avg_cm       <= avg_n;
                    near         <= near_n;
                    sample_valid <= 1'b1;
                    timeout      <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= StUpdate;
                end
                StUpdate: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
